clb_config_loader: RTL and testbench

//   Upstream configuration stage for the CLB_3 array. Receives a serial bitstream over a

---
 rtl/clb_cfg_pkg.sv | 10 +
 rtl/clb_config_loader_if.sv | 12 +
 rtl/clb_cfg_shadow.sv | 43 ++++
 rtl/clb_config_loader.sv | 145 ++++++++++++++
 tb/tb_clb_config_loader.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/clb_cfg_pkg.sv
// Shared widths and FSM state encoding for the CLB configuration loader.
package clb_cfg_pkg;

  localparam int LUT_W        = 8;
  localparam int CLB_CFG_BITS = 9;
  localparam int CKSUM_W      = 8;

  typedef enum logic [1:0] {IDLE, LOAD, CHECK, COMMIT} cfg_state_t;

endpackage

// File: rtl/clb_config_loader_if.sv
// Serial config bitstream handshake: source drives start/bit/valid, loader drives ready.
interface clb_config_loader_if;

  logic cfg_start;
  logic cfg_bit;
  logic cfg_valid;
  logic cfg_ready;

  modport master (output cfg_start, output cfg_bit, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_start, input cfg_bit, input cfg_valid, output cfg_ready);

endinterface

// File: rtl/clb_cfg_shadow.sv
// Shadow LUT/select storage written one bit per slot, plus XOR of completed LUT bytes.
// Slot s maps to CLB s/9, position s%9: positions 0..7 are LUT[7..0], position 8 is sel.
module clb_cfg_shadow
  import clb_cfg_pkg::*;
#(
  parameter int NUM_CLB = 4,
  parameter int CNT_W   = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     acc_clr,
  input  logic                     wr_en,
  input  logic [CNT_W-1:0]         slot,
  input  logic                     din,
  output logic [LUT_W*NUM_CLB-1:0] lut_shadow,
  output logic [NUM_CLB-1:0]       sel_shadow,
  output logic [CKSUM_W-1:0]       acc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lut_shadow <= '0;
      sel_shadow <= '0;
      acc        <= '0;
    end else if (acc_clr) begin
      acc <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < NUM_CLB; k++) begin
        for (int p = 0; p < LUT_W; p++) begin
          if (slot == CNT_W'(k*CLB_CFG_BITS + p)) begin
            lut_shadow[k*LUT_W + LUT_W-1 - p] <= din;
            // Last LUT bit closes the byte: fold it in using the incoming bit directly.
            if (p == LUT_W-1)
              acc <= acc ^ {lut_shadow[k*LUT_W + LUT_W-1 -: LUT_W-1], din};
          end
        end
        if (slot == CNT_W'(k*CLB_CFG_BITS + LUT_W))
          sel_shadow[k] <= din;
      end
    end
  end

endmodule

// File: rtl/clb_config_loader.sv
// Serial CLB config loader: assembles LUT/select per CLB, checks XOR checksum, commits atomically.
// Commit lands on the COMMIT exit edge after the last checksum bit; cfg_valid low stalls with no state change.
module clb_config_loader
  import clb_cfg_pkg::*;
#(
  parameter int NUM_CLB = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  clb_config_loader_if.slave       cfg,
  output logic [LUT_W*NUM_CLB-1:0] lut_cfg,
  output logic [NUM_CLB-1:0]       sel_cfg,
  output logic                     busy,
  output logic                     cfg_done,
  output logic                     cfg_err
);

  localparam int DATA_BITS = CLB_CFG_BITS * NUM_CLB;
  localparam int CNT_W     = $clog2(DATA_BITS + 1);

  cfg_state_t                 state, state_nxt;
  logic [CNT_W-1:0]           cnt;
  logic [CKSUM_W-1:0]         rx_cksum;
  logic [LUT_W*NUM_CLB-1:0]   lut_shadow;
  logic [NUM_CLB-1:0]         sel_shadow;
  logic [CKSUM_W-1:0]         acc;

  logic ready_c, busy_c;
  logic cnt_clr, cnt_inc, acc_clr, flags_clr;
  logic shadow_wr, cksum_shift, commit_ok, commit_bad;

  assign cfg.cfg_ready = ready_c;
  assign busy          = busy_c;

  always_comb begin
    state_nxt   = state;
    ready_c     = 1'b0;
    busy_c      = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    acc_clr     = 1'b0;
    flags_clr   = 1'b0;
    shadow_wr   = 1'b0;
    cksum_shift = 1'b0;
    commit_ok   = 1'b0;
    commit_bad  = 1'b0;
    case (state)
      IDLE: begin
        if (cfg.cfg_start) begin
          state_nxt = LOAD;
          cnt_clr   = 1'b1;
          acc_clr   = 1'b1;
          flags_clr = 1'b1;
        end
      end
      LOAD: begin
        ready_c = 1'b1;
        busy_c  = 1'b1;
        if (cfg.cfg_start) begin
          cnt_clr = 1'b1;
          acc_clr = 1'b1;
        end else if (cfg.cfg_valid) begin
          shadow_wr = 1'b1;
          if (cnt == CNT_W'(DATA_BITS - 1)) begin
            cnt_clr   = 1'b1;
            state_nxt = CHECK;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      CHECK: begin
        ready_c = 1'b1;
        busy_c  = 1'b1;
        if (cfg.cfg_start) begin
          cnt_clr   = 1'b1;
          acc_clr   = 1'b1;
          state_nxt = LOAD;
        end else if (cfg.cfg_valid) begin
          cksum_shift = 1'b1;
          if (cnt == CNT_W'(CKSUM_W - 1)) begin
            cnt_clr   = 1'b1;
            state_nxt = COMMIT;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      COMMIT: begin
        busy_c     = 1'b1;
        commit_ok  = (acc == rx_cksum);
        commit_bad = (acc != rx_cksum);
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      rx_cksum <= '0;
      lut_cfg  <= '0;
      sel_cfg  <= '0;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cnt_clr)
        cnt <= '0;
      else if (cnt_inc)
        cnt <= cnt + CNT_W'(1);
      if (cksum_shift)
        rx_cksum <= {rx_cksum[CKSUM_W-2:0], cfg.cfg_bit};
      if (flags_clr) begin
        cfg_done <= 1'b0;
        cfg_err  <= 1'b0;
      end
      if (commit_ok) begin
        lut_cfg  <= lut_shadow;
        sel_cfg  <= sel_shadow;
        cfg_done <= 1'b1;
      end
      if (commit_bad)
        cfg_err <= 1'b1;
    end
  end

  clb_cfg_shadow #(
    .NUM_CLB (NUM_CLB),
    .CNT_W   (CNT_W)
  ) u_shadow (
    .clk        (clk),
    .reset      (reset),
    .acc_clr    (acc_clr),
    .wr_en      (shadow_wr),
    .slot       (cnt),
    .din        (cfg.cfg_bit),
    .lut_shadow (lut_shadow),
    .sel_shadow (sel_shadow),
    .acc        (acc)
  );

endmodule

// File: tb/tb_clb_config_loader.sv
// Directed bench for clb_config_loader with two CLBs and hand-computed frames.
module tb_clb_config_loader;

  logic        clk;
  logic        reset;
  logic [15:0] lut_cfg;
  logic [1:0]  sel_cfg;
  logic        busy, cfg_done, cfg_err;
  int          n_cmp, n_bad;

  clb_config_loader_if cfg_if ();

  clb_config_loader #(.NUM_CLB(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .cfg      (cfg_if),
    .lut_cfg  (lut_cfg),
    .sel_cfg  (sel_cfg),
    .busy     (busy),
    .cfg_done (cfg_done),
    .cfg_err  (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    cfg_if.cfg_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cfg_if.cfg_start = 1'b0;
  endtask

  // Sends the first nbits of {lut0, sel0, lut1, sel1, cksum}, MSB first; returns at the
  // negedge after the last accepting edge.
  task automatic send_bits(input logic [7:0] l0, input logic s0, input logic [7:0] l1,
                           input logic s1, input logic [7:0] ck, input int nbits,
                           input bit stall);
    logic [25:0] bits;
    bits = {l0, s0, l1, s1, ck};
    for (int i = 0; i < nbits; i++) begin
      if (stall) begin
        repeat ($urandom_range(1, 0)) begin
          cfg_if.cfg_valid = 1'b0;
          cfg_if.cfg_bit   = 1'b1;
          @(posedge clk);
          @(negedge clk);
        end
      end
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_bit   = bits[25 - i];
      @(posedge clk);
      @(negedge clk);
    end
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_bit   = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cfg_if.cfg_start = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_bit   = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // 1: reset state held through idle cycles
    repeat (5) @(negedge clk);
    chk("rst_lut",   32'(lut_cfg),   32'h0);
    chk("rst_sel",   32'(sel_cfg),   32'h0);
    chk("rst_ready", 32'(cfg_if.cfg_ready), 32'h0);
    chk("rst_done",  32'(cfg_done),  32'h0);
    chk("rst_err",   32'(cfg_err),   32'h0);
    chk("rst_busy",  32'(busy),      32'h0);

    // 2: good frame, 33^A5 = 96
    pulse_start();
    chk("load_ready", 32'(cfg_if.cfg_ready), 32'h1);
    send_bits(8'h33, 1'b0, 8'hA5, 1'b1, 8'h96, 26, 1'b0);
    chk("commit_busy",     32'(busy),     32'h1);
    chk("commit_ready",    32'(cfg_if.cfg_ready), 32'h0);
    chk("commit_lut_hold", 32'(lut_cfg),  32'h0);
    chk("commit_done_lo",  32'(cfg_done), 32'h0);
    @(negedge clk);
    chk("good_lut",  32'(lut_cfg),  32'hA533);
    chk("good_sel",  32'(sel_cfg),  32'h2);
    chk("good_done", 32'(cfg_done), 32'h1);
    chk("good_err",  32'(cfg_err),  32'h0);
    chk("good_busy", 32'(busy),     32'h0);

    // 3: same frame, wrong checksum
    pulse_start();
    chk("start_clr_done", 32'(cfg_done), 32'h0);
    send_bits(8'h33, 1'b0, 8'hA5, 1'b1, 8'h97, 26, 1'b0);
    @(negedge clk);
    chk("bad_err",  32'(cfg_err),  32'h1);
    chk("bad_done", 32'(cfg_done), 32'h0);
    chk("bad_lut",  32'(lut_cfg),  32'hA533);
    chk("bad_sel",  32'(sel_cfg),  32'h2);

    // 4: stalled frame, FF^0F = F0
    pulse_start();
    chk("start_clr_err", 32'(cfg_err), 32'h0);
    send_bits(8'hFF, 1'b1, 8'h0F, 1'b0, 8'hF0, 26, 1'b1);
    @(negedge clk);
    chk("stall_lut",  32'(lut_cfg),  32'h0FFF);
    chk("stall_sel",  32'(sel_cfg),  32'h1);
    chk("stall_done", 32'(cfg_done), 32'h1);

    // 5: abort after 7 bits; the bit offered alongside the restart is dropped
    pulse_start();
    send_bits(8'hFF, 1'b1, 8'hFF, 1'b1, 8'hFF, 7, 1'b0);
    cfg_if.cfg_start = 1'b1;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_bit   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cfg_if.cfg_start = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    chk("abort_lut_hold", 32'(lut_cfg), 32'h0FFF);
    chk("abort_busy",     32'(busy),    32'h1);
    send_bits(8'h33, 1'b0, 8'hA5, 1'b1, 8'h96, 26, 1'b0);
    @(negedge clk);
    chk("abort_lut",  32'(lut_cfg),  32'hA533);
    chk("abort_sel",  32'(sel_cfg),  32'h2);
    chk("abort_done", 32'(cfg_done), 32'h1);

    // 6: reset in CHECK (18 data + 3 checksum bits), then a clean frame; 5A^C3 = 99
    pulse_start();
    send_bits(8'h11, 1'b1, 8'h22, 1'b1, 8'h33, 21, 1'b0);
    chk("mid_lut_hold", 32'(lut_cfg), 32'hA533);
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_lut",   32'(lut_cfg),  32'h0);
    chk("mrst_sel",   32'(sel_cfg),  32'h0);
    chk("mrst_done",  32'(cfg_done), 32'h0);
    chk("mrst_busy",  32'(busy),     32'h0);
    chk("mrst_ready", 32'(cfg_if.cfg_ready), 32'h0);
    reset = 1'b0;
    @(negedge clk);
    pulse_start();
    send_bits(8'h5A, 1'b1, 8'hC3, 1'b0, 8'h99, 26, 1'b0);
    @(negedge clk);
    chk("post_lut",  32'(lut_cfg),  32'hC35A);
    chk("post_sel",  32'(sel_cfg),  32'h1);
    chk("post_done", 32'(cfg_done), 32'h1);
    chk("post_err",  32'(cfg_err),  32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
